// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: takes FFT output in bit-reversed order and
// streams it out in natural frequency order, one sample per clock.
module fft_bitrev_reorder #(
    parameter int DATA_WIDTH = 25,
    parameter int FFT_N      = 1024,
    parameter int FFT_NLOG2  = 10
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic                         valid_i,
    input  logic        [FFT_NLOG2-1:0]  cnt_i,
    input  logic signed [DATA_WIDTH-1:0] x_re_i,
    input  logic signed [DATA_WIDTH-1:0] x_im_i,
    output logic                         valid_o,
    output logic        [FFT_NLOG2-1:0]  cnt_o,
    output logic signed [DATA_WIDTH-1:0] z_re_o,
    output logic signed [DATA_WIDTH-1:0] z_im_o,
    output logic                         last_o,
    output logic                         ovf_o
);

    localparam logic [FFT_NLOG2-1:0] LAST_IDX = FFT_NLOG2'(FFT_N - 1);

    typedef enum logic {
        S_IDLE,
        S_READ
    } state_t;

    function automatic logic [FFT_NLOG2-1:0] bitrev(input logic [FFT_NLOG2-1:0] a);
        logic [FFT_NLOG2-1:0] r;
        for (int k = 0; k < FFT_NLOG2; k++) begin
            r[FFT_NLOG2-1-k] = a[k];
        end
        return r;
    endfunction

    logic [2*DATA_WIDTH-1:0] r_mem [2][FFT_N];
    logic [2*DATA_WIDTH-1:0] r_rd_data;

    logic                 r_wr_bank;
    logic                 r_synced;
    logic [1:0]           r_full;
    logic [1:0]           w_full_nxt;
    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_rd_bank;
    logic                 w_rd_bank_nxt;
    logic [FFT_NLOG2-1:0] r_rd_addr;
    logic [FFT_NLOG2-1:0] w_rd_addr_nxt;
    logic                 r_rd_vld;
    logic [FFT_NLOG2-1:0] r_rd_cnt;

    logic                 w_wr_en;
    logic                 w_frame_end;
    logic                 w_oth_bank;
    logic                 w_rd_last;
    logic                 w_other_busy;
    logic                 w_commit;
    logic                 w_drop;

    // Samples are ignored until a frame start is seen, so a frame cut by reset never completes.
    assign w_wr_en     = valid_i && (r_synced || (cnt_i == '0));
    assign w_frame_end = w_wr_en && (cnt_i == LAST_IDX);
    assign w_oth_bank  = ~r_wr_bank;
    assign w_rd_last   = (r_state == S_READ) && (r_rd_addr == LAST_IDX);

    // A bank finishing its last read on this edge counts as free, which keeps streaming gapless.
    assign w_other_busy = r_full[w_oth_bank] && !(w_rd_last && (r_rd_bank == w_oth_bank));
    assign w_commit     = w_frame_end && !w_other_busy;
    assign w_drop       = w_frame_end && w_other_busy;

    // NOTE: the sample buffers carry no reset; only the control state has to be known after reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_bank][bitrev(cnt_i)] <= {x_re_i, x_im_i};
        end
        r_rd_data <= r_mem[r_rd_bank][r_rd_addr];
    end

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        w_full_nxt = r_full;
        if (w_rd_last) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_commit) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rd_bank_nxt = r_rd_bank;
        w_rd_addr_nxt = r_rd_addr;
        case (r_state)
            S_IDLE: begin
                if (r_full != 2'b00) begin
                    w_state_nxt   = S_READ;
                    w_rd_bank_nxt = (&r_full) ? r_wr_bank : r_full[1];
                    w_rd_addr_nxt = '0;
                end else if (w_commit) begin
                    w_state_nxt   = S_READ;
                    w_rd_bank_nxt = r_wr_bank;
                    w_rd_addr_nxt = '0;
                end
            end
            S_READ: begin
                if (!w_rd_last) begin
                    w_rd_addr_nxt = r_rd_addr + FFT_NLOG2'(1);
                end else if (w_full_nxt[~r_rd_bank]) begin
                    w_rd_bank_nxt = ~r_rd_bank;
                    w_rd_addr_nxt = '0;
                end else begin
                    w_state_nxt   = S_IDLE;
                    w_rd_addr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rd_bank <= 1'b0;
            r_rd_addr <= '0;
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_synced  <= 1'b0;
            ovf_o     <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_rd_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_bank <= w_rd_bank_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_full    <= w_full_nxt;
            r_synced  <= r_synced || (valid_i && (cnt_i == '0));
            r_rd_vld  <= (r_state == S_READ);
            r_rd_cnt  <= r_rd_addr;
            if (w_commit) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_drop) begin
                ovf_o <= 1'b1;
            end
        end
    end

    // Data and index hold their last value between bursts.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            cnt_o   <= '0;
            z_re_o  <= '0;
            z_im_o  <= '0;
        end else begin
            valid_o <= r_rd_vld;
            last_o  <= r_rd_vld && (r_rd_cnt == LAST_IDX);
            if (r_rd_vld) begin
                cnt_o  <= r_rd_cnt;
                z_re_o <= r_rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
                z_im_o <= r_rd_data[DATA_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder at FFT_N=16: scoreboard of natural-order
// samples queued on each frame's final input, popped as the DUT emits them.
module tb_fft_bitrev_reorder;

    localparam int DW = 25;
    localparam int N  = 16;
    localparam int LG = 4;

    typedef struct packed {
        logic [LG-1:0] cnt;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } exp_t;

    logic                 clk_i = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 valid_i = 1'b0;
    logic        [LG-1:0] cnt_i = '0;
    logic signed [DW-1:0] x_re_i = '0;
    logic signed [DW-1:0] x_im_i = '0;
    logic                 valid_o;
    logic        [LG-1:0] cnt_o;
    logic signed [DW-1:0] z_re_o;
    logic signed [DW-1:0] z_im_o;
    logic                 last_o;
    logic                 ovf_o;

    fft_bitrev_reorder #(
        .DATA_WIDTH(DW),
        .FFT_N     (N),
        .FFT_NLOG2 (LG)
    ) dut (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .valid_i(valid_i),
        .cnt_i  (cnt_i),
        .x_re_i (x_re_i),
        .x_im_i (x_im_i),
        .valid_o(valid_o),
        .cnt_o  (cnt_o),
        .z_re_o (z_re_o),
        .z_im_o (z_im_o),
        .last_o (last_o),
        .ovf_o  (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    exp_t          sb[$];
    logic [DW-1:0] f_re[N];
    logic [DW-1:0] f_im[N];
    int n_vec = 0, n_err = 0;
    int cyc = 0, last_cyc = 0, rise_cyc = 0;
    int n_out = 0, n_rise = 0;
    int base_out, base_rise;
    bit prev_v = 1'b0;
    bit found;

    function automatic logic [LG-1:0] brev(input logic [LG-1:0] a);
        logic [LG-1:0] r;
        for (int k = 0; k < LG; k++) r[LG-1-k] = a[k];
        return r;
    endfunction

    function automatic logic [63:0] z(input logic [DW-1:0] v);
        return {39'b0, v};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (!rst_n) begin
            prev_v = 1'b0;
            return;
        end
        if (valid_o) begin
            n_out++;
            if (!prev_v) begin
                n_rise++;
                rise_cyc = cyc;
            end
            n_vec++;
            assert (sb.size() != 0)
            else begin
                n_err++;
                $error("FAIL unexpected_output: observed cnt_o=%0d expected no output", cnt_o);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("cnt_o", z({21'b0, cnt_o}), z({21'b0, e.cnt}));
                check("z_re_o", z(z_re_o), z(e.re));
                check("z_im_o", z(z_im_o), z(e.im));
                check("last_o", last_o, (e.cnt == LG'(N - 1)));
            end
        end
        prev_v = valid_o;
    endtask

    task automatic tick();
        @(negedge clk_i);
        cyc++;
        monitor();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_frame();
        for (int b = 0; b < N; b++) sb.push_back('{cnt: LG'(b), re: f_re[b], im: f_im[b]});
    endtask

    task automatic send_sample(input int c, input logic [DW-1:0] re, input logic [DW-1:0] im);
        valid_i = 1'b1;
        cnt_i   = LG'(c);
        x_re_i  = re;
        x_im_i  = im;
        tick();
        valid_i = 1'b0;
    endtask

    // Input slot j carries natural-order bin brev(j).
    task automatic send_frame(input int gap_pct, input bit keep);
        logic [LG-1:0] cj, bj;
        for (int j = 0; j < N; j++) begin
            while ($urandom_range(99) < gap_pct) begin
                valid_i = 1'b0;
                tick();
            end
            cj = LG'(j);
            bj = brev(cj);
            if (j == N - 1 && keep) push_frame();
            valid_i = 1'b1;
            cnt_i   = cj;
            x_re_i  = f_re[bj];
            x_im_i  = f_im[bj];
            tick();
            if (j == N - 1) last_cyc = cyc;
        end
        valid_i = 1'b0;
    endtask

    task automatic gen_frame();
        for (int b = 0; b < N; b++) begin
            case ($urandom_range(3))
                0:       f_re[b] = 25'h1000000;
                1:       f_re[b] = 25'h0FFFFFF;
                default: f_re[b] = DW'($urandom);
            endcase
            case ($urandom_range(3))
                0:       f_im[b] = 25'h0FFFFFF;
                1:       f_im[b] = 25'h1000000;
                default: f_im[b] = DW'($urandom);
            endcase
        end
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 200 && sb.size() != 0; c++) tick();
        repeat (4) tick();
        check(tag, sb.size(), 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #10;
        check("rst_valid_o", valid_o, 1'b0);
        check("rst_last_o", last_o, 1'b0);
        check("rst_ovf_o", ovf_o, 1'b0);
        check("rst_cnt_o", z({21'b0, cnt_o}), 0);
        check("rst_z_re_o", z(z_re_o), 0);
        check("rst_z_im_o", z(z_im_o), 0);
        #11 rst_n = 1'b1;
        @(posedge clk_i);
        #1;
        repeat (2) tick();

        // Ramp frame: z_re = bin, z_im = -bin.
        for (int b = 0; b < N; b++) begin
            f_re[b] = DW'(b);
            f_im[b] = DW'(-b);
        end
        base_out = n_out;
        base_rise = n_rise;
        send_frame(0, 1'b1);
        drain("s1_drain");
        check("s1_latency", rise_cyc - last_cyc, 3);
        check("s1_bursts", n_rise - base_rise, 1);
        check("s1_count", n_out - base_out, 16);
        check("s1_ovf_o", ovf_o, 1'b0);
        check("s1_hold_valid", valid_o, 1'b0);
        check("s1_hold_last", last_o, 1'b0);
        check("s1_hold_cnt", z({21'b0, cnt_o}), 15);
        check("s1_hold_re", z(z_re_o), z(DW'(15)));
        check("s1_hold_im", z(z_im_o), z(DW'(-15)));

        // Four back-to-back frames with extreme values.
        base_out = n_out;
        base_rise = n_rise;
        for (int f = 0; f < 4; f++) begin
            gen_frame();
            send_frame(0, 1'b1);
        end
        drain("s2_drain");
        check("s2_bursts", n_rise - base_rise, 1);
        check("s2_count", n_out - base_out, 64);
        check("s2_ovf_o", ovf_o, 1'b0);

        // Ramp frame again with ~50% input gaps.
        for (int b = 0; b < N; b++) begin
            f_re[b] = DW'(b);
            f_im[b] = DW'(-b);
        end
        base_out = n_out;
        base_rise = n_rise;
        send_frame(50, 1'b1);
        drain("s3_drain");
        check("s3_bursts", n_rise - base_rise, 1);
        check("s3_count", n_out - base_out, 16);

        // Two full frames, then a short frame completing while the second is still unread.
        base_out = n_out;
        base_rise = n_rise;
        gen_frame();
        send_frame(0, 1'b1);
        gen_frame();
        send_frame(0, 1'b1);
        check("s4_ovf_before", ovf_o, 1'b0);
        for (int j = 12; j < N; j++) send_sample(j, DW'($urandom), DW'($urandom));
        check("s4_ovf_set", ovf_o, 1'b1);
        drain("s4_drain");
        check("s4_bursts", n_rise - base_rise, 1);
        check("s4_count", n_out - base_out, 32);
        gen_frame();
        send_frame(0, 1'b1);
        drain("s4_after_drain");
        check("s4_ovf_sticky", ovf_o, 1'b1);

        // Asynchronous reset in the middle of an output burst.
        gen_frame();
        send_frame(0, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk_i);
            cyc++;
            monitor();
            if (valid_o && cnt_o == LG'(7)) begin
                found = 1'b1;
                break;
            end
            @(posedge clk_i);
            #1;
        end
        check("s5_reach_cnt7", found, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("s5_rst_valid_o", valid_o, 1'b0);
        check("s5_rst_last_o", last_o, 1'b0);
        check("s5_rst_ovf_o", ovf_o, 1'b0);
        check("s5_rst_cnt_o", z({21'b0, cnt_o}), 0);
        check("s5_rst_z_re_o", z(z_re_o), 0);
        sb.delete();
        @(posedge clk_i);
        #1;
        check("s5_rst_hold_valid", valid_o, 1'b0);
        #1 rst_n = 1'b1;
        base_out = n_out;
        for (int j = 8; j < N; j++) send_sample(j, DW'($urandom), DW'($urandom));
        repeat (20) tick();
        check("s5_no_partial_out", n_out - base_out, 0);
        gen_frame();
        base_rise = n_rise;
        send_frame(0, 1'b1);
        drain("s5_drain");
        check("s5_count", n_out - base_out, 16);
        check("s5_bursts", n_rise - base_rise, 1);
        check("s5_ovf_o", ovf_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
